// File: rtl/des_key_pkg.sv
// Shared DES key-schedule tables, FSM encoding and reset key constants.
// Table entries use FIPS 46-3 numbering: bit 1 is the most significant bit.
package des_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [63:0] RESET_KEY_0 = 64'hAAAA_FFFF_AAAA_FFFF;
    localparam logic [63:0] RESET_KEY_1 = 64'hAAAA_FCFF_AAAA_FFFF;

    localparam byte unsigned PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam byte unsigned PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Per-round left-rotation amounts; entry 0 is round 1.
    localparam logic [1:0] SHIFT_TABLE [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[6'(55 - i)] = key[6'(64 - int'(PC1_TABLE[6'(i)]))];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[6'(47 - i)] = cd[6'(56 - int'(PC2_TABLE[6'(i)]))];
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_key_store.sv
// Key register file: synchronous write, asynchronous read, two preset keys on reset.
module des_key_store
    import des_key_pkg::*;
#(
    parameter int KEY_SLOTS = 4,
    parameter int ADDR_W    = $clog2(KEY_SLOTS)
) (
    input  logic              clk,
    input  logic              reset_bar,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wr_data,
    output logic [63:0]       rd_data
);

    logic [63:0] mem [KEY_SLOTS];
    logic        addr_ok;

    // Guards non-power-of-two slot counts against out-of-range addresses.
    assign addr_ok = int'(addr) < KEY_SLOTS;

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            for (int i = 0; i < KEY_SLOTS; i++)
                mem[i] <= (i == 0) ? RESET_KEY_0 : (i == 1) ? RESET_KEY_1 : 64'h0;
        end else if (wr_en && addr_ok) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = addr_ok ? mem[addr] : 64'h0;

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: presents 16 subkeys from a stored key, in encrypt or decrypt order.
//   state   | meaning
//   ST_IDLE | waiting for START; key store writable
//   ST_LOAD | one cycle: pre-rotate C,D for encrypt order
//   ST_RUN  | subkey presented, advances on SUBKEY_VALID & SUBKEY_READY
//   ST_DONE | one cycle after the 16th key is accepted
module des_key_schedule
    import des_key_pkg::*;
#(
    parameter  int KEY_SLOTS = 4,
    localparam int ADDR_W    = $clog2(KEY_SLOTS)
) (
    input  logic              CLK,
    input  logic              RESET_BAR,
    input  logic              CHIP_SELECT_BAR,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic              LOAD_KEY,
    input  logic [63:0]       LOAD_DATA,
    input  logic              START,
    input  logic              MODE,
    input  logic              SUBKEY_READY,
    output logic [47:0]       SUBKEY,
    output logic              SUBKEY_VALID,
    output logic [3:0]        ROUND,
    output logic              BUSY,
    output logic              DONE
);

    state_t      state, state_nxt;
    logic        mode_q;
    logic [3:0]  round_q;
    logic [27:0] c_q, d_q;
    logic [63:0] slot_key;
    logic        cs, accept, last_accept;

    assign cs           = !CHIP_SELECT_BAR;
    assign BUSY         = (state != ST_IDLE);
    assign SUBKEY_VALID = (state == ST_RUN);
    assign accept       = SUBKEY_VALID && SUBKEY_READY && cs;
    assign last_accept  = accept && (round_q == 4'd15);
    assign DONE         = last_accept && RESET_BAR;
    assign ROUND        = round_q;
    assign SUBKEY       = SUBKEY_VALID ? pc2({c_q, d_q}) : 48'h0;

    des_key_store #(
        .KEY_SLOTS (KEY_SLOTS),
        .ADDR_W    (ADDR_W)
    ) u_store (
        .clk       (CLK),
        .reset_bar (RESET_BAR),
        .wr_en     (LOAD_KEY && cs && !BUSY),
        .addr      (ADDRESS),
        .wr_data   (LOAD_DATA),
        .rd_data   (slot_key)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (START && cs) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (last_accept) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && !cs)
            state_nxt = ST_IDLE;
    end

    // PC1 is captured at START so a same-cycle write cannot alter this schedule.
    always_ff @(posedge CLK) begin
        if (!RESET_BAR) begin
            state   <= ST_IDLE;
            mode_q  <= 1'b0;
            round_q <= 4'd0;
            c_q     <= 28'h0;
            d_q     <= 28'h0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (START && cs) begin
                        mode_q     <= MODE;
                        {c_q, d_q} <= pc1(slot_key);
                    end
                end
                ST_LOAD: begin
                    if (!mode_q) begin
                        c_q <= rotl28(c_q, SHIFT_TABLE[0]);
                        d_q <= rotl28(d_q, SHIFT_TABLE[0]);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        round_q <= round_q + 4'd1;
                        if (!mode_q) begin
                            c_q <= rotl28(c_q, SHIFT_TABLE[round_q + 4'd1]);
                            d_q <= rotl28(d_q, SHIFT_TABLE[round_q + 4'd1]);
                        end else begin
                            c_q <= rotr28(c_q, SHIFT_TABLE[4'd15 - round_q]);
                            d_q <= rotr28(d_q, SHIFT_TABLE[4'd15 - round_q]);
                        end
                    end
                end
                default: ;
            endcase
            if (state != ST_IDLE && !cs) begin
                round_q <= 4'd0;
                c_q     <= 28'h0;
                d_q     <= 28'h0;
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a table-driven DES key-schedule model.
module tb_des_key_schedule;

    localparam int ADDR_W = 2;
    localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic              CLK = 1'b0;
    logic              RESET_BAR = 1'b0;
    logic              CHIP_SELECT_BAR = 1'b1;
    logic [ADDR_W-1:0] ADDRESS = '0;
    logic              LOAD_KEY = 1'b0;
    logic [63:0]       LOAD_DATA = '0;
    logic              START = 1'b0;
    logic              MODE = 1'b0;
    logic              SUBKEY_READY = 1'b0;
    logic [47:0]       SUBKEY;
    logic              SUBKEY_VALID;
    logic [3:0]        ROUND;
    logic              BUSY;
    logic              DONE;

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;

    des_key_schedule dut (
        .CLK             (CLK),
        .RESET_BAR       (RESET_BAR),
        .CHIP_SELECT_BAR (CHIP_SELECT_BAR),
        .ADDRESS         (ADDRESS),
        .LOAD_KEY        (LOAD_KEY),
        .LOAD_DATA       (LOAD_DATA),
        .START           (START),
        .MODE            (MODE),
        .SUBKEY_READY    (SUBKEY_READY),
        .SUBKEY          (SUBKEY),
        .SUBKEY_VALID    (SUBKEY_VALID),
        .ROUND           (ROUND),
        .BUSY            (BUSY),
        .DONE            (DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Round key idx (1..16): PC2 of PC1 halves each rotated left by the cumulative shift total.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int idx);
        logic [47:0] r;
        int tot, p, src;
        tot = 0;
        for (int j = 0; j < idx; j++) tot += SH_T[j];
        r = '0;
        for (int m = 0; m < 48; m++) begin
            p = PC2_T[m];
            if (p <= 28) src = PC1_T[(p - 1 + tot) % 28];
            else         src = PC1_T[28 + (p - 29 + tot) % 28];
            r[6'(47 - m)] = key[6'(64 - src)];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_subkey"}, SUBKEY, 0);
        check({tag, "_valid"}, SUBKEY_VALID, 0);
        check({tag, "_round"}, ROUND, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
    endtask

    task automatic load_key(input int slot, input logic [63:0] val);
        @(negedge CLK);
        CHIP_SELECT_BAR = 1'b0;
        ADDRESS = ADDR_W'(slot);
        LOAD_DATA = val;
        LOAD_KEY = 1'b1;
        @(negedge CLK);
        LOAD_KEY = 1'b0;
    endtask

    // ev_kind: 0 none, 1 START+LOAD_KEY while busy, 2 chip-select abort, 3 reset.
    task automatic run_sched(input int slot, input logic [63:0] key, input bit mode,
                             input int stall_at, input int stall_len,
                             input int ev_at, input int ev_kind,
                             input bit ld_same, input logic [63:0] ld_val, input string tag,
                             output logic [47:0] first_sub, output logic [47:0] last_sub);
        logic [47:0] exp_k [16];
        int n, stalls, t, done_edge;
        bit stop, ev_done, ready;
        for (int i = 0; i < 16; i++) exp_k[i] = ref_subkey(key, mode ? 16 - i : i + 1);
        first_sub = '0;
        last_sub = '0;
        done_edge = -1;
        @(negedge CLK);
        CHIP_SELECT_BAR = 1'b0;
        ADDRESS = ADDR_W'(slot);
        MODE = mode;
        START = 1'b1;
        SUBKEY_READY = 1'b1;
        LOAD_KEY = ld_same;
        LOAD_DATA = ld_val;
        t = cyc + 1;
        @(negedge CLK);
        START = 1'b0;
        LOAD_KEY = 1'b0;
        MODE = ~mode;
        #1;
        check({tag, "_load_busy"}, BUSY, 1);
        check({tag, "_load_valid"}, SUBKEY_VALID, 0);
        check({tag, "_load_subkey"}, SUBKEY, 0);
        n = 0; stalls = 0; stop = 0; ev_done = 0;
        for (int guard = 0; guard < 64 && n < 16 && !stop; guard++) begin
            @(negedge CLK);
            START = 1'b0;
            LOAD_KEY = 1'b0;
            CHIP_SELECT_BAR = 1'b0;
            ready = !(n == stall_at && stalls < stall_len);
            if (!ready) stalls++;
            SUBKEY_READY = ready;
            if (!ev_done && n == ev_at && ev_kind != 0) begin
                ev_done = 1;
                case (ev_kind)
                    1: begin START = 1'b1; LOAD_KEY = 1'b1; LOAD_DATA = ~key; MODE = ~mode; end
                    2: begin CHIP_SELECT_BAR = 1'b1; START = 1'b1; LOAD_KEY = 1'b1; LOAD_DATA = ~key; end
                    default: RESET_BAR = 1'b0;
                endcase
                stop = (ev_kind >= 2);
            end
            #1;
            if (guard == 0) check({tag, "_first_valid_edge"}, cyc + 1, t + 2);
            check({tag, "_valid"}, SUBKEY_VALID, 1);
            check({tag, "_round"}, ROUND, n);
            check({tag, "_subkey"}, SUBKEY, exp_k[4'(n)]);
            if (stop) begin
                check({tag, "_abort_done"}, DONE, 0);
            end else if (ready) begin
                check({tag, "_done_pulse"}, DONE, (n == 15));
                if (n == 0) first_sub = SUBKEY;
                if (n == 15) begin last_sub = SUBKEY; done_edge = cyc + 1; end
                n++;
            end
        end
        @(negedge CLK);
        RESET_BAR = 1'b1;
        CHIP_SELECT_BAR = 1'b0;
        START = 1'b0;
        LOAD_KEY = 1'b0;
        SUBKEY_READY = 1'b1;
        #1;
        if (stop) begin
            check_idle_outputs({tag, "_aborted"});
            @(negedge CLK);
            #1;
            check({tag, "_after_abort_busy"}, BUSY, 0);
            check({tag, "_after_abort_done"}, DONE, 0);
        end else begin
            check({tag, "_keys_presented"}, n, 16);
            check({tag, "_done_edge"}, done_edge, t + 17 + stall_len);
            check({tag, "_done_state_busy"}, BUSY, 1);
            check({tag, "_done_state_valid"}, SUBKEY_VALID, 0);
            check({tag, "_done_state_subkey"}, SUBKEY, 0);
            check({tag, "_done_state_done"}, DONE, 0);
            @(negedge CLK);
            #1;
            check({tag, "_back_idle"}, BUSY, 0);
        end
    endtask

    initial begin
        logic [47:0] f, l;
        logic [63:0] rk, rk2;
        repeat (3) @(negedge CLK);
        #1;
        check_idle_outputs("reset");
        @(negedge CLK);
        RESET_BAR = 1'b1;
        CHIP_SELECT_BAR = 1'b0;

        load_key(2, KEY_A);
        run_sched(2, KEY_A, 0, -1, 0, -1, 0, 0, '0, "enc", f, l);
        check("enc_k1_vector", f, 48'h1B02EFFC7072);
        check("enc_k16_vector", l, 48'hCB3D8B0E17F5);
        run_sched(2, KEY_A, 1, -1, 0, -1, 0, 0, '0, "dec", f, l);
        check("dec_first_vector", f, 48'hCB3D8B0E17F5);
        check("dec_last_vector", l, 48'h1B02EFFC7072);
        run_sched(2, KEY_A, 0, 5, 3, -1, 0, 0, '0, "stall", f, l);

        load_key(3, KEY_A ^ 64'h0101_0101_0101_0101);
        run_sched(3, KEY_A, 0, -1, 0, -1, 0, 0, '0, "parity", f, l);

        run_sched(0, 64'hAAAA_FFFF_AAAA_FFFF, 0, -1, 0, -1, 0, 0, '0, "slot0", f, l);
        run_sched(1, 64'hAAAA_FCFF_AAAA_FFFF, 1, -1, 0, -1, 0, 0, '0, "slot1", f, l);

        for (int k = 0; k < 4; k++) begin
            int s;
            rk = {$urandom, $urandom};
            s = int'($urandom_range(0, 3));
            load_key(s, rk);
            run_sched(s, rk, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 4)), -1, 0, 0, '0, "rand", f, l);
        end

        rk = {$urandom, $urandom};
        load_key(2, KEY_A);
        run_sched(2, KEY_A, 0, -1, 0, -1, 0, 1, rk, "same_cycle_old", f, l);
        run_sched(2, rk, 1, -1, 0, -1, 0, 0, '0, "same_cycle_new", f, l);

        run_sched(2, rk, 0, -1, 0, 3, 1, 0, '0, "busy_ignore", f, l);
        run_sched(2, rk, 0, -1, 0, 7, 2, 0, '0, "cs_abort", f, l);
        run_sched(2, rk, 0, -1, 0, -1, 0, 0, '0, "slot_kept", f, l);

        rk2 = {$urandom, $urandom};
        load_key(0, rk2);
        run_sched(0, rk2, 0, -1, 0, 9, 3, 0, '0, "reset_mid", f, l);
        run_sched(0, 64'hAAAA_FFFF_AAAA_FFFF, 0, -1, 0, -1, 0, 0, '0, "slot0_restored", f, l);
        run_sched(2, 64'h0, 1, -1, 0, -1, 0, 0, '0, "slot2_cleared", f, l);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
